operands: RTL and testbench
===========================

OPERANDS -- requirements
Module: operands

Interface
REQ-001 The parameter EXP_W SHALL default to 8 and set the exponent field width.
REQ-002 The parameter FRAC_W SHALL default to 23 and set the fraction field width; operand width is 1+EXP_W+FRAC_W (32).
REQ-003 The port clk_i SHALL be an input, 1 bit wide, and be the single clock; all state updates on its rising edge.
REQ-004 The port rst_i SHALL be an input, 1 bit wide, and be a synchronous, active-high reset.
REQ-005 The port valid_i SHALL be an input, 1 bit wide, and indicate that x_i/y_i are to be captured this cycle.
REQ-006 The ports x_i and y_i SHALL be inputs, 32 bits wide, carrying IEEE-754 single-precision operands.
REQ-007 The port valid_o SHALL be an output, 1 bit wide, and indicate that all other outputs hold a newly decoded pair.
REQ-008 The ports x_sign_o and y_sign_o SHALL be outputs, 1 bit wide, carrying operand bit 31.
REQ-009 The ports x_exp_o and y_exp_o SHALL be outputs, 8 bits wide, carrying operand bits 30:23 (raw biased exponent).
REQ-010 The ports x_frac_o and y_frac_o SHALL be outputs, 23 bits wide, carrying operand bits 22:0.
REQ-011 The port x_greater_o SHALL be an output, 1 bit wide, and be 1 when x exponent > y exponent.
REQ-012 The port exp_shift_o SHALL be an output, 8 bits wide, carrying |x_exp - y_exp|.
REQ-013 The ports x_infinity_o, y_infinity_o, x_nan_o and y_nan_o SHALL be outputs, 1 bit wide, carrying the special-value flags.
REQ-014 The ports x_zero_o, y_zero_o, x_denorm_o and y_denorm_o SHALL be outputs, 1 bit wide, carrying the zero/subnormal flags.

Function
REQ-015 When valid_i=1 at a rising edge, all decoded outputs SHALL reflect that x_i/y_i pair on the following cycle (latency 1), and valid_o SHALL be 1 for that cycle.
REQ-016 When valid_i=0, valid_o SHALL be 0 next cycle and all other outputs SHALL hold their last values.
REQ-017 Sign, exponent and fraction outputs SHALL be exact bit slices of the operands, with no bias removal or hidden bit.
REQ-018 x_greater_o SHALL be 0 when the exponents are equal, with the comparison unsigned.
REQ-019 exp_shift_o SHALL be the unsigned absolute difference (0..255) and SHALL never wrap (for example, 0xff vs 0x00 gives 0xff).
REQ-020 The infinity flag SHALL be 1 when exp=0xff and frac=0; the NaN flag SHALL be 1 when exp=0xff and frac!=0; these two flags are mutually exclusive.
REQ-021 The zero flag SHALL be 1 when exp=0 and frac=0, regardless of sign; the denorm flag SHALL be 1 when exp=0 and frac!=0.
REQ-022 Flag and shift computation SHALL be independent of sign bits.
REQ-023 Back-to-back valid_i SHALL be accepted every cycle with no stall and no backpressure.

Reset
REQ-024 While rst_i=1 at a rising edge, every output, including valid_o, SHALL be cleared to 0 next cycle.
REQ-025 Reset SHALL take priority over valid_i in the same cycle.
REQ-026 A capture in flight SHALL be discarded by reset, and no valid_o is produced for it.
REQ-027 After rst_i deasserts, the first valid_i SHALL produce valid_o one cycle later.

Structure
REQ-028 A shared package fpu_pkg SHALL hold EXP_W, FRAC_W, EXP_MAX (0xff), and a packed struct fp32_t {sign, exp, frac}.
REQ-029 A sub-module fp_classify SHALL decode one operand combinationally into sign/exp/frac/inf/nan/zero/denorm, and SHALL be instantiated twice.
REQ-030 Exponent compare/subtract and the output register stage SHALL reside in operands.

Verification
REQ-031 x=3fc00000, y=4500001a -> x_exp=7f, y_exp=8a, x_frac=400000, y_frac=00001a, x_greater=0, shift=0b, all flags 0.
REQ-032 x=7f800000, y=baa3d70a -> x_inf=1, x_nan=0, y_sign=1, y_exp=75, x_greater=1, shift=8a.
REQ-033 x=7fffffff, y=c0c28f5c -> x_nan=1, x_inf=0, y_exp=81, x_greater=1, shift=7e; swapping x and y gives y_nan=1 and x_greater=0.
REQ-034 x=00000000, y=80000000 -> x_sign=0, y_sign=1, x_zero=y_zero=1, shift=00, x_greater=0.
REQ-035 x=00000001, y=7f800000 -> x_denorm=1, y_inf=1, shift=ff, x_greater=0.
REQ-036 Protocol: valid pulse, then valid_i=0 -> outputs held and valid_o=0; rst_i asserted together with valid_i -> all outputs 0 next cycle.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared single-precision field widths, exponent limit and operand layout.
package fpu_pkg;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hff;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

endpackage

// File: rtl/fp_classify.sv
// Combinational field split and special-value classification of one operand.
module fp_classify #(
  parameter int unsigned EXP_W  = fpu_pkg::EXP_W,
  parameter int unsigned FRAC_W = fpu_pkg::FRAC_W
) (
  input  logic [EXP_W+FRAC_W:0] op_i,
  output logic                  sign_o,
  output logic [EXP_W-1:0]      exp_o,
  output logic [FRAC_W-1:0]     frac_o,
  output logic                  inf_o,
  output logic                  nan_o,
  output logic                  zero_o,
  output logic                  denorm_o
);
  import fpu_pkg::*;

  logic exp_ones;
  logic exp_zero;
  logic frac_zero;

  assign sign_o = op_i[EXP_W+FRAC_W];
  assign exp_o  = op_i[FRAC_W +: EXP_W];
  assign frac_o = op_i[FRAC_W-1:0];

  // Classification ignores the sign bit entirely.
  assign exp_ones  = &exp_o;
  assign exp_zero  = ~|exp_o;
  assign frac_zero = ~|frac_o;

  assign inf_o    = exp_ones & frac_zero;
  assign nan_o    = exp_ones & ~frac_zero;
  assign zero_o   = exp_zero & frac_zero;
  assign denorm_o = exp_zero & ~frac_zero;

endmodule

// File: rtl/operands.sv
// Decodes an x/y operand pair, compares exponents and registers the result (latency 1).
module operands #(
  parameter int unsigned EXP_W  = fpu_pkg::EXP_W,
  parameter int unsigned FRAC_W = fpu_pkg::FRAC_W
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic [EXP_W+FRAC_W:0] x_i,
  input  logic [EXP_W+FRAC_W:0] y_i,
  output logic                  valid_o,
  output logic                  x_sign_o,
  output logic                  y_sign_o,
  output logic [EXP_W-1:0]      x_exp_o,
  output logic [EXP_W-1:0]      y_exp_o,
  output logic [FRAC_W-1:0]     x_frac_o,
  output logic [FRAC_W-1:0]     y_frac_o,
  output logic                  x_greater_o,
  output logic [EXP_W-1:0]      exp_shift_o,
  output logic                  x_infinity_o,
  output logic                  y_infinity_o,
  output logic                  x_nan_o,
  output logic                  y_nan_o,
  output logic                  x_zero_o,
  output logic                  y_zero_o,
  output logic                  x_denorm_o,
  output logic                  y_denorm_o
);
  import fpu_pkg::*;

  logic              x_sign_d, y_sign_d;
  logic [EXP_W-1:0]  x_exp_d, y_exp_d;
  logic [FRAC_W-1:0] x_frac_d, y_frac_d;
  logic              x_inf_d, y_inf_d, x_nan_d, y_nan_d;
  logic              x_zero_d, y_zero_d, x_denorm_d, y_denorm_d;
  logic              x_greater_d;
  logic [EXP_W-1:0]  exp_shift_d;

  fp_classify #(
    .EXP_W  (EXP_W),
    .FRAC_W (FRAC_W)
  ) u_x_classify (
    .op_i     (x_i),
    .sign_o   (x_sign_d),
    .exp_o    (x_exp_d),
    .frac_o   (x_frac_d),
    .inf_o    (x_inf_d),
    .nan_o    (x_nan_d),
    .zero_o   (x_zero_d),
    .denorm_o (x_denorm_d)
  );

  fp_classify #(
    .EXP_W  (EXP_W),
    .FRAC_W (FRAC_W)
  ) u_y_classify (
    .op_i     (y_i),
    .sign_o   (y_sign_d),
    .exp_o    (y_exp_d),
    .frac_o   (y_frac_d),
    .inf_o    (y_inf_d),
    .nan_o    (y_nan_d),
    .zero_o   (y_zero_d),
    .denorm_o (y_denorm_d)
  );

  // Subtract smaller from larger so the difference never wraps.
  always_comb begin
    x_greater_d = x_exp_d > y_exp_d;
    exp_shift_d = x_greater_d ? (x_exp_d - y_exp_d) : (y_exp_d - x_exp_d);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o      <= 1'b0;
      x_sign_o     <= 1'b0;
      y_sign_o     <= 1'b0;
      x_exp_o      <= '0;
      y_exp_o      <= '0;
      x_frac_o     <= '0;
      y_frac_o     <= '0;
      x_greater_o  <= 1'b0;
      exp_shift_o  <= '0;
      x_infinity_o <= 1'b0;
      y_infinity_o <= 1'b0;
      x_nan_o      <= 1'b0;
      y_nan_o      <= 1'b0;
      x_zero_o     <= 1'b0;
      y_zero_o     <= 1'b0;
      x_denorm_o   <= 1'b0;
      y_denorm_o   <= 1'b0;
    end else begin
      valid_o <= valid_i;
      // Decoded fields hold their last value between captures.
      if (valid_i) begin
        x_sign_o     <= x_sign_d;
        y_sign_o     <= y_sign_d;
        x_exp_o      <= x_exp_d;
        y_exp_o      <= y_exp_d;
        x_frac_o     <= x_frac_d;
        y_frac_o     <= y_frac_d;
        x_greater_o  <= x_greater_d;
        exp_shift_o  <= exp_shift_d;
        x_infinity_o <= x_inf_d;
        y_infinity_o <= y_inf_d;
        x_nan_o      <= x_nan_d;
        y_nan_o      <= y_nan_d;
        x_zero_o     <= x_zero_d;
        y_zero_o     <= y_zero_d;
        x_denorm_o   <= x_denorm_d;
        y_denorm_o   <= y_denorm_d;
      end
    end
  end

endmodule

// File: tb/tb_operands.sv
// Randomized scoreboard bench for operands against a behavioural decode model.
module tb_operands;
  import fpu_pkg::*;

  typedef struct packed {
    logic        valid;
    logic        xs, ys;
    logic [7:0]  xe, ye;
    logic [22:0] xf, yf;
    logic        xg;
    logic [7:0]  sh;
    logic        xinf, yinf, xnan, ynan, xz, yz, xd, yd;
  } out_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i = 1'b0;
  logic [31:0] x_i = '0, y_i = '0;
  logic        valid_o, x_sign_o, y_sign_o, x_greater_o;
  logic [7:0]  x_exp_o, y_exp_o, exp_shift_o;
  logic [22:0] x_frac_o, y_frac_o;
  logic        x_infinity_o, y_infinity_o, x_nan_o, y_nan_o;
  logic        x_zero_o, y_zero_o, x_denorm_o, y_denorm_o;

  operands dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .valid_i      (valid_i),
    .x_i          (x_i),
    .y_i          (y_i),
    .valid_o      (valid_o),
    .x_sign_o     (x_sign_o),
    .y_sign_o     (y_sign_o),
    .x_exp_o      (x_exp_o),
    .y_exp_o      (y_exp_o),
    .x_frac_o     (x_frac_o),
    .y_frac_o     (y_frac_o),
    .x_greater_o  (x_greater_o),
    .exp_shift_o  (exp_shift_o),
    .x_infinity_o (x_infinity_o),
    .y_infinity_o (y_infinity_o),
    .x_nan_o      (x_nan_o),
    .y_nan_o      (y_nan_o),
    .x_zero_o     (x_zero_o),
    .y_zero_o     (y_zero_o),
    .x_denorm_o   (x_denorm_o),
    .y_denorm_o   (y_denorm_o)
  );

  always #5 clk = ~clk;

  out_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic rst_seen = 1'b0;

  always @(posedge clk) rst_seen <= rst_i;

  // Reference decode: plain integer arithmetic on the IEEE-754 bit layout.
  function automatic out_t model(input logic [31:0] x, input logic [31:0] y);
    out_t m;
    int unsigned xe, ye, xf, yf;
    xe = (x / 32'h0080_0000) % 256;
    ye = (y / 32'h0080_0000) % 256;
    xf = x % 32'h0080_0000;
    yf = y % 32'h0080_0000;
    m.valid = 1'b1;
    m.xs    = x >= 32'h8000_0000;
    m.ys    = y >= 32'h8000_0000;
    m.xe    = 8'(xe);
    m.ye    = 8'(ye);
    m.xf    = 23'(xf);
    m.yf    = 23'(yf);
    m.xg    = xe > ye;
    m.sh    = 8'((xe > ye) ? xe - ye : ye - xe);
    m.xinf  = (xe == 255) && (xf == 0);
    m.yinf  = (ye == 255) && (yf == 0);
    m.xnan  = (xe == 255) && (xf != 0);
    m.ynan  = (ye == 255) && (yf != 0);
    m.xz    = (xe == 0) && (xf == 0);
    m.yz    = (ye == 0) && (yf == 0);
    m.xd    = (xe == 0) && (xf != 0);
    m.yd    = (ye == 0) && (yf != 0);
    return m;
  endfunction

  function automatic logic [31:0] rand_op();
    fp32_t op;
    op.sign = 1'($urandom);
    case ($urandom_range(0, 3))
      0:       op.exp = '0;
      1:       op.exp = EXP_MAX;
      default: op.exp = 8'($urandom);
    endcase
    op.frac = ($urandom_range(0, 2) == 0) ? '0 : 23'($urandom);
    return op;
  endfunction

  task automatic drive(input logic v, input logic r, input logic [31:0] x, input logic [31:0] y);
    @(posedge clk);
    #1;
    valid_i = v;
    rst_i   = r;
    x_i     = x;
    y_i     = y;
    if (v && !r) sb.push_back(model(x, y));
  endtask

  // Monitor: pops on valid_o, otherwise expects held (or reset-cleared) fields.
  out_t last = '0;
  initial begin
    out_t got, want;
    forever begin
      @(negedge clk);
      got = {valid_o, x_sign_o, y_sign_o, x_exp_o, y_exp_o, x_frac_o, y_frac_o,
             x_greater_o, exp_shift_o, x_infinity_o, y_infinity_o, x_nan_o, y_nan_o,
             x_zero_o, y_zero_o, x_denorm_o, y_denorm_o};
      if (rst_seen) begin
        want = '0;
        last = '0;
      end else if (valid_o) begin
        if (sb.size() == 0) begin
          want = last;
          want.valid = 1'b0;
        end else begin
          want = sb.pop_front();
          last = want;
        end
      end else begin
        want = last;
        want.valid = 1'b0;
      end
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL decode @%0t: got %h, want %h", $time, got, want);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    drive(1'b0, 1'b1, '0, '0);
    drive(1'b0, 1'b1, '0, '0);
    drive(1'b0, 1'b0, '0, '0);
    // Directed corner pairs, with idle gaps to exercise holding.
    drive(1'b1, 1'b0, 32'h3fc0_0000, 32'h4500_001a);
    drive(1'b0, 1'b0, 32'hdead_beef, 32'h1234_5678);
    drive(1'b1, 1'b0, 32'h7f80_0000, 32'hbaa3_d70a);
    drive(1'b1, 1'b0, 32'h7fff_ffff, 32'hc0c2_8f5c);
    drive(1'b1, 1'b0, 32'hc0c2_8f5c, 32'h7fff_ffff);
    drive(1'b0, 1'b0, '0, '0);
    drive(1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 32'h0000_0000, 32'h8000_0000);
    drive(1'b1, 1'b0, 32'h0000_0001, 32'h7f80_0000);
    drive(1'b1, 1'b0, 32'h7f80_0000, 32'h0000_0001);
    // Reset together with valid discards the capture.
    drive(1'b1, 1'b1, 32'h4000_0000, 32'h3f80_0000);
    drive(1'b1, 1'b0, 32'h4000_0000, 32'h3f80_0000);
    drive(1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0, rand_op(), rand_op());
    end
    drive(1'b0, 1'b0, '0, '0);
    drive(1'b0, 1'b0, '0, '0);
    drive(1'b0, 1'b0, '0, '0);
    @(posedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected outputs never seen, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
